// File: rtl/htif_pkg.sv
// Shared HTIF definitions: exit-command encoding, channel-index width
// helper and the sticky exit flags carried by the mailbox.
package htif_pkg;

  localparam int HTIF_XLEN = 64;
  localparam int EXIT_BIT  = 0;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef struct packed {
    logic done;
    logic fail;
  } exit_flags_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push into a full FIFO is accepted only when a
// pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp;
  logic [AW:0]      r_rp;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty = (r_wp == r_rp);
  assign full  = (r_wp[AW] != r_rp[AW]) &&
                 (r_wp[AW-1:0] == r_rp[AW-1:0]);

  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign dout = r_mem[r_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_do_push) r_wp <= r_wp + (AW+1)'(1);
      if (w_do_pop)  r_rp <= r_rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tohost_mailbox.sv
// Multi-hart tohost mailbox: per-channel FIFOs, round-robin merge into a
// single registered host port, and sticky capture of the first exit.
module tohost_mailbox
  import htif_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int XLEN  = HTIF_XLEN,
  parameter int DEPTH = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [NCH-1:0]            tohost_we,
  input  logic [NCH*XLEN-1:0]       tohost,
  output logic                      host_valid,
  input  logic                      host_ready,
  output logic [ch_width(NCH)-1:0]  host_ch,
  output logic [XLEN-1:0]           host_data,
  output logic                      done,
  output logic                      fail,
  output logic [XLEN-2:0]           exit_code,
  output logic [ch_width(NCH)-1:0]  exit_ch,
  output logic [NCH-1:0]            overflow
);

  localparam int CHW = ch_width(NCH);

  logic [XLEN-1:0] w_dout [NCH];
  logic [NCH-1:0]  w_full;
  logic [NCH-1:0]  w_empty;
  logic [NCH-1:0]  w_pop;
  logic [CHW-1:0]  w_grant;
  logic            w_any;
  logic            w_load;
  logic            w_hs;

  logic            r_valid;
  logic [CHW-1:0]  r_ch;
  logic [XLEN-1:0] r_data;
  logic [CHW-1:0]  r_last;
  logic [NCH-1:0]  r_ovf;
  exit_flags_t     r_exit;
  logic [XLEN-2:0] r_code;
  logic [CHW-1:0]  r_xch;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (tohost_we[g]),
      .pop   (w_pop[g]),
      .din   (tohost[g*XLEN +: XLEN]),
      .dout  (w_dout[g]),
      .full  (w_full[g]),
      .empty (w_empty[g])
    );
  end

  // Scan downward so the nearest channel after r_last wins.
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = '0;
    w_any   = 1'b0;
    for (int k = NCH; k >= 1; k--) begin
      idx = (int'(r_last) + k) % NCH;
      if (!w_empty[idx]) begin
        w_grant = CHW'(idx);
        w_any   = 1'b1;
      end
    end
  end

  assign w_load = w_any && (!r_valid || host_ready);
  assign w_pop  = w_load ? (NCH'(1) << w_grant) : '0;
  assign w_hs   = r_valid && host_ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_valid <= 1'b0;
      r_ch    <= '0;
      r_data  <= '0;
      r_last  <= CHW'(NCH-1);
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_ch    <= w_grant;
      r_data  <= w_dout[w_grant];
      r_last  <= w_grant;
    end else if (host_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) r_ovf <= '0;
    else     r_ovf <= r_ovf | (tohost_we & w_full & ~w_pop);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_exit <= '0;
      r_code <= '0;
      r_xch  <= '0;
    end else if (w_hs && r_data[EXIT_BIT] && !r_exit.done) begin
      r_exit.done <= 1'b1;
      r_exit.fail <= |r_data[XLEN-1:1];
      r_code      <= r_data[XLEN-1:1];
      r_xch       <= r_ch;
    end
  end

  assign host_valid = r_valid;
  assign host_ch    = r_ch;
  assign host_data  = r_data;
  assign done       = r_exit.done;
  assign fail       = r_exit.fail;
  assign exit_code  = r_code;
  assign exit_ch    = r_xch;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_tohost_mailbox.sv
// Directed bench for tohost_mailbox (NCH=2, XLEN=64, DEPTH=4) with a
// scoreboard of expected {channel, word} pairs checked at each handshake.
module tb_tohost_mailbox;

  logic         CLK = 1'b0;
  logic         RST;
  logic [1:0]   tohost_we;
  logic [127:0] tohost;
  logic         host_valid;
  logic         host_ready;
  logic [0:0]   host_ch;
  logic [63:0]  host_data;
  logic         done;
  logic         fail;
  logic [62:0]  exit_code;
  logic [0:0]   exit_ch;
  logic [1:0]   overflow;

  int n_tests = 0;
  int n_fail  = 0;
  logic [64:0] sb [$];

  tohost_mailbox #(.NCH(2), .XLEN(64), .DEPTH(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .tohost_we  (tohost_we),
    .tohost     (tohost),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_ch    (host_ch),
    .host_data  (host_data),
    .done       (done),
    .fail       (fail),
    .exit_code  (exit_code),
    .exit_ch    (exit_ch),
    .overflow   (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check any handshake happening at the coming edge, then advance.
  task automatic tick();
    logic [64:0] e;
    if (host_valid && host_ready) begin
      n_tests++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL unexpected_word observed=%0h expected=none",
               host_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("hs_ch", 64'(host_ch), 64'(e[64]));
        chk("hs_data", host_data, e[63:0]);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int ch, input logic [63:0] d, input bit exp);
    tohost_we[ch] = 1'b1;
    tohost[ch*64 +: 64] = d;
    if (exp) sb.push_back({ch[0], d});
  endtask

  task automatic idle();
    tohost_we = '0;
    tohost    = '0;
  endtask

  task automatic do_reset();
    host_ready = 1'b0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    sb.delete();
  endtask

  initial begin
    RST = 1'b1;
    host_ready = 1'b0;
    idle();
    @(posedge CLK);
    #1;
    tick();
    RST = 1'b0;

    chk("rst_valid", 64'(host_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_code", 64'(exit_code), 64'd0);
    chk("rst_xch", 64'(exit_ch), 64'd0);
    chk("rst_ch", 64'(host_ch), 64'd0);
    chk("rst_data", host_data, 64'd0);

    // single word latency
    host_ready = 1'b1;
    wr(0, 64'h10, 1);
    tick();
    idle();
    chk("lat_t1_valid", 64'(host_valid), 64'd0);
    tick();
    chk("lat_t2_valid", 64'(host_valid), 64'd1);
    chk("lat_t2_ch", 64'(host_ch), 64'd0);
    chk("lat_t2_data", host_data, 64'h10);
    tick();
    chk("lat_t3_valid", 64'(host_valid), 64'd0);

    // round robin
    do_reset();
    host_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr(0, 64'h100 + 64'(i * 16), 1);
      wr(1, 64'h200 + 64'(i * 16), 1);
      tick();
    end
    idle();
    repeat (8) tick();
    chk("rr_drained", 64'(sb.size()), 64'd0);

    // backpressure and overflow: 6 pushed, only 5 can be held
    host_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr(1, 64'h300 + 64'(i * 16), i < 5);
      tick();
    end
    idle();
    chk("ovf_flag", 64'(overflow), 64'b10);
    chk("bp_valid", 64'(host_valid), 64'd1);
    chk("bp_data", host_data, 64'h300);
    repeat (3) tick();
    chk("bp_stable_data", host_data, 64'h300);
    chk("bp_stable_ch", 64'(host_ch), 64'd1);
    host_ready = 1'b1;
    repeat (8) tick();
    chk("bp_drained", 64'(sb.size()), 64'd0);
    chk("bp_valid_end", 64'(host_valid), 64'd0);

    // exit pass on channel 1
    wr(1, 64'h1, 1);
    tick();
    idle();
    tick();
    chk("pass_pre_done", 64'(done), 64'd0);
    tick();
    chk("pass_done", 64'(done), 64'd1);
    chk("pass_fail", 64'(fail), 64'd0);
    chk("pass_code", 64'(exit_code), 64'd0);
    chk("pass_xch", 64'(exit_ch), 64'd1);

    // reset mid-operation, with a write during reset
    host_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr(0, 64'h400 + 64'(i * 16), 0);
      tick();
    end
    idle();
    chk("mid_valid_pre", 64'(host_valid), 64'd1);
    RST = 1'b1;
    wr(0, 64'h500, 0);
    tick();
    RST = 1'b0;
    idle();
    chk("mid_valid", 64'(host_valid), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    chk("mid_fail", 64'(fail), 64'd0);
    chk("mid_ovf", 64'(overflow), 64'd0);
    host_ready = 1'b1;
    repeat (6) tick();
    chk("mid_no_stale", 64'(host_valid), 64'd0);

    // exit fail, then a later exit and a plain word
    wr(0, 64'h7, 1);
    tick();
    idle();
    repeat (3) tick();
    chk("fail_done", 64'(done), 64'd1);
    chk("fail_fail", 64'(fail), 64'd1);
    chk("fail_code", 64'(exit_code), 64'd3);
    chk("fail_xch", 64'(exit_ch), 64'd0);
    wr(1, 64'h1, 1);
    tick();
    idle();
    repeat (3) tick();
    wr(0, 64'h20, 1);
    tick();
    idle();
    repeat (3) tick();
    chk("second_done", 64'(done), 64'd1);
    chk("second_fail", 64'(fail), 64'd1);
    chk("second_code", 64'(exit_code), 64'd3);
    chk("second_xch", 64'(exit_ch), 64'd0);
    chk("final_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
